// File: rtl/cn_explode_pkg.sv
// Shared defaults and FSM encoding for the explode-unit job scheduler.
package cn_explode_pkg;

    localparam int STATE_WIDTH_DEF = 1600;
    localparam int NONCE_WIDTH_DEF = 7;
    localparam int N_UNITS_DEF     = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester found searching from (i_last+1) mod N upward.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int          pos;
        logic [IW-1:0] cand;
        pos     = 0;
        cand    = '0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
        for (int off = N; off >= 1; off--) begin
            pos  = (int'(i_last) + off) % N;
            cand = pos[IW-1:0];
            if (i_req[cand]) begin
                o_grant       = '0;
                o_grant[cand] = 1'b1;
                o_idx         = cand;
                o_any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/explode_scheduler.sv
// Single-slot job scheduler feeding N explode units round-robin.
// Optional per-unit busy watchdog enabled by defining EXPLODE_SCHED_WATCHDOG_EN.
module explode_scheduler
    import cn_explode_pkg::*;
#(
    parameter int state_width = STATE_WIDTH_DEF,
    parameter int nonce_width = NONCE_WIDTH_DEF,
    parameter int N_UNITS     = N_UNITS_DEF,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_valid,
    input  logic [state_width-1:0]       i_v_state,
    input  logic [nonce_width-1:0]       i_v_nonce,
    output logic                         o_ready,
    output logic [state_width-1:0]       o_v_state,
    output logic [nonce_width-1:0]       o_v_nonce,
    output logic [N_UNITS-1:0]           o_unit_valid,
    input  logic [N_UNITS-1:0]           i_unit_ready,
    input  logic [N_UNITS-1:0]           i_unit_done,
    output logic [N_UNITS-1:0]           o_busy,
    output logic [$clog2(N_UNITS+1)-1:0] o_inflight,
    output logic [N_UNITS-1:0]           o_unit_rstn,
    output logic [N_UNITS-1:0]           o_timeout,
    output sched_state_t                 o_state
);

    localparam int IW  = $clog2(N_UNITS);
    localparam int IFW = $clog2(N_UNITS+1);

    if (N_UNITS < 2 || N_UNITS > 16) begin : g_bad_units
        $error("explode_scheduler: N_UNITS must be in 2..16");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("explode_scheduler: WDOG_CYCLES must be at least 1");
    end

    sched_state_t           state_q, state_d;
    logic [state_width-1:0] hold_state_q, hold_state_d;
    logic [nonce_width-1:0] hold_nonce_q, hold_nonce_d;
    logic [N_UNITS-1:0]     busy_q, busy_d;
    logic [IW-1:0]          last_q, last_d;
    logic [N_UNITS-1:0]     unit_valid_q, unit_valid_d;
    logic [N_UNITS-1:0]     unit_rstn_q, unit_rstn_d;
    logic [N_UNITS-1:0]     arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic                   accept;
    logic [N_UNITS-1:0]     grant_vec;
    logic [N_UNITS-1:0]     free_vec;
    logic [N_UNITS-1:0]     wdog_expire;
    logic [IFW-1:0]         inflight;

    rr_arbiter #(.N(N_UNITS), .IW(IW)) u_rr_arbiter (
        .i_req   (~busy_q & i_unit_ready),
        .i_last  (last_q),
        .o_grant (arb_grant),
        .o_idx   (arb_idx),
        .o_any   (arb_any)
    );

    // Handshake: a job moves when i_valid and o_ready are both high at a rising edge.
    assign o_ready = (state_q == ST_EMPTY) && rstn;

    always_comb begin
        state_d      = state_q;
        hold_state_d = hold_state_q;
        hold_nonce_d = hold_nonce_q;
        last_d       = last_q;
        grant_vec    = '0;
        accept       = i_valid && o_ready;
        case (state_q)
            ST_EMPTY: if (accept) begin
                hold_state_d = i_v_state;
                hold_nonce_d = i_v_nonce;
                state_d      = ST_FULL;
            end
            ST_FULL: if (arb_any) begin
                grant_vec = arb_grant;
                last_d    = arb_idx;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        // A freed unit still shows busy this cycle, so it cannot be re-granted on the same edge.
        free_vec     = (i_unit_done & busy_q) | wdog_expire;
        busy_d       = (busy_q & ~free_vec) | grant_vec;
        unit_valid_d = grant_vec;
        unit_rstn_d  = ~free_vec;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_EMPTY;
            hold_state_q <= '0;
            hold_nonce_q <= '0;
            busy_q       <= '0;
            last_q       <= IW'(N_UNITS-1);
            unit_valid_q <= '0;
            unit_rstn_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_state_q <= hold_state_d;
            hold_nonce_q <= hold_nonce_d;
            busy_q       <= busy_d;
            last_q       <= last_d;
            unit_valid_q <= unit_valid_d;
            unit_rstn_q  <= unit_rstn_d;
        end
    end

`ifdef EXPLODE_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES+1);

    logic [WW-1:0]      wdog_q [N_UNITS];
    logic [WW-1:0]      wdog_d [N_UNITS];
    logic [N_UNITS-1:0] timeout_q, timeout_d;

    // Counter sits at zero while idle, so a fresh grant always starts from zero.
    always_comb begin
        wdog_expire = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            wdog_expire[k] = busy_q[k] && (wdog_q[k] == WW'(WDOG_CYCLES-1));
            if (!busy_q[k] || i_unit_done[k] || wdog_expire[k]) begin
                wdog_d[k] = '0;
            end else begin
                wdog_d[k] = wdog_q[k] + 1'b1;
            end
        end
        timeout_d = timeout_q | wdog_expire;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            timeout_q <= '0;
            for (int k = 0; k < N_UNITS; k++) wdog_q[k] <= '0;
        end else begin
            timeout_q <= timeout_d;
            for (int k = 0; k < N_UNITS; k++) wdog_q[k] <= wdog_d[k];
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wdog_expire = '0;
    assign o_timeout   = '0;
`endif

    always_comb begin
        inflight = '0;
        for (int k = 0; k < N_UNITS; k++) inflight = inflight + IFW'(busy_q[k]);
    end

    assign o_inflight   = inflight;
    assign o_v_state    = hold_state_q;
    assign o_v_nonce    = hold_nonce_q;
    assign o_unit_valid = unit_valid_q;
    assign o_busy       = busy_q;
    assign o_unit_rstn  = unit_rstn_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_explode_scheduler.sv
// Directed bench for explode_scheduler; issues are checked against an expected queue.
module tb_explode_scheduler;
    import cn_explode_pkg::*;

    localparam int SW  = 1600;
    localparam int NW  = 7;
    localparam int NU  = 4;
    localparam int WD  = 16;
    localparam int IFW = $clog2(NU+1);
    localparam int EW  = NU + NW;

    logic           clk = 1'b0;
    logic           rstn;
    logic           i_valid;
    logic [SW-1:0]  i_v_state;
    logic [NW-1:0]  i_v_nonce;
    logic           o_ready;
    logic [SW-1:0]  o_v_state;
    logic [NW-1:0]  o_v_nonce;
    logic [NU-1:0]  o_unit_valid;
    logic [NU-1:0]  i_unit_ready;
    logic [NU-1:0]  i_unit_done;
    logic [NU-1:0]  o_busy;
    logic [IFW-1:0] o_inflight;
    logic [NU-1:0]  o_unit_rstn;
    logic [NU-1:0]  o_timeout;
    sched_state_t   o_state;

    explode_scheduler #(
        .state_width (SW),
        .nonce_width (NW),
        .N_UNITS     (NU),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_valid      (i_valid),
        .i_v_state    (i_v_state),
        .i_v_nonce    (i_v_nonce),
        .o_ready      (o_ready),
        .o_v_state    (o_v_state),
        .o_v_nonce    (o_v_nonce),
        .o_unit_valid (o_unit_valid),
        .i_unit_ready (i_unit_ready),
        .i_unit_done  (i_unit_done),
        .o_busy       (o_busy),
        .o_inflight   (o_inflight),
        .o_unit_rstn  (o_unit_rstn),
        .o_timeout    (o_timeout),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    logic [EW-1:0] exp_q[$];
    logic [SW-1:0] st_q[$];
    logic [EW-1:0] mon_e;
    logic [SW-1:0] mon_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every issue strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_unit_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'(o_unit_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_s = st_q.pop_front();
                check("issue_unit", 64'(o_unit_valid), 64'(mon_e[EW-1:NW]));
                check("issue_nonce", 64'(o_v_nonce), 64'(mon_e[NW-1:0]));
                check("issue_state", 64'(o_v_state == mon_s), 64'd1);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_job(input logic [NW-1:0] nonce, input logic [NU-1:0] unit,
                            input bit push, output int acc_cyc);
        int            n;
        logic [SW-1:0] st;
        n = 0;
        while (!o_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("ready_timeout", 64'(o_ready), 64'd1);
        for (int i = 0; i < SW/32; i++) st[i*32 +: 32] = $urandom;
        i_valid   = 1'b1;
        i_v_state = st;
        i_v_nonce = nonce;
        if (push) begin
            exp_q.push_back({unit, nonce});
            st_q.push_back(st);
        end
        acc_cyc = cyc;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        i_valid     = 1'b0;
        i_unit_done = '0;
        tick();
        tick();
        exp_q.delete();
        st_q.delete();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc[5];
        int a;
        int n;

        rstn         = 1'b0;
        i_valid      = 1'b0;
        i_v_state    = '0;
        i_v_nonce    = '0;
        i_unit_ready = '1;
        i_unit_done  = '0;
        tick();
        tick();
        check("rst_ready",     64'(o_ready), 64'd0);
        check("rst_busy",      64'(o_busy), 64'd0);
        check("rst_inflight",  64'(o_inflight), 64'd0);
        check("rst_unit_rstn", 64'(o_unit_rstn), 64'd0);
        check("rst_valid",     64'(o_unit_valid), 64'd0);
        check("rst_nonce",     64'(o_v_nonce), 64'd0);
        check("rst_vstate",    64'(o_v_state == '0), 64'd1);
        check("rst_state",     64'(o_state), 64'(ST_EMPTY));
        check("rst_timeout",   64'(o_timeout), 64'd0);
        rstn = 1'b1;
        tick();
        check("rel_unit_rstn", 64'(o_unit_rstn), 64'hf);
        check("rel_ready",     64'(o_ready), 64'd1);

        // Single job, nonce 0x05, lands on unit 0.
        send_job(7'h05, 4'b0001, 1'b1, a);
        check("t28_full",  64'(o_state), 64'(ST_FULL));
        check("t28_ready", 64'(o_ready), 64'd0);
        tick();
        check("t28_valid",    64'(o_unit_valid), 64'b0001);
        check("t28_nonce",    64'(o_v_nonce), 64'h05);
        check("t28_busy",     64'(o_busy), 64'b0001);
        check("t28_inflight", 64'(o_inflight), 64'd1);
        tick();
        check("t28_empty",     64'(o_state), 64'(ST_EMPTY));
        check("t28_valid_off", 64'(o_unit_valid), 64'd0);
        check("t28_hold",      64'(o_v_nonce), 64'h05);
        check("t28_ready_bk",  64'(o_ready), 64'd1);
        i_unit_done = 4'b0001;
        tick();
        i_unit_done = '0;
        check("t28_done_busy", 64'(o_busy), 64'd0);
        check("t28_done_urst", 64'(o_unit_rstn), 64'b1110);
        tick();
        check("t28_urst_back", 64'(o_unit_rstn), 64'hf);
        i_unit_done = 4'b1000;
        tick();
        i_unit_done = '0;
        check("t28_ign_busy", 64'(o_busy), 64'd0);
        check("t28_ign_urst", 64'(o_unit_rstn), 64'hf);

        // Four back-to-back jobs, then a fifth that must wait for a unit.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_job(7'(8'h10 + k), 4'(1 << k), 1'b1, acc[k]);
        end
        for (int k = 1; k < 4; k++) check("t29_spacing", 64'(acc[k] - acc[k-1]), 64'd3);
        send_job(7'h20, 4'b0100, 1'b1, acc[4]);
        repeat (10) tick();
        check("t29_hold_state", 64'(o_state), 64'(ST_FULL));
        check("t29_hold_ready", 64'(o_ready), 64'd0);
        check("t29_hold_busy",  64'(o_busy), 64'hf);
        check("t29_inflight",   64'(o_inflight), 64'd4);
        i_unit_done = 4'b0100;
        tick();
        i_unit_done = '0;
        check("t29_freed_busy",  64'(o_busy), 64'b1011);
        check("t29_freed_state", 64'(o_state), 64'(ST_FULL));
        tick();
        check("t29_regrant_busy", 64'(o_busy), 64'hf);
        drain(10);

        // Done on unit 1 on the same edge as a grant to unit 3.
        do_reset();
        send_job(7'h30, 4'b0001, 1'b1, a);
        drain(10);
        send_job(7'h31, 4'b0010, 1'b1, a);
        drain(10);
        i_unit_ready = 4'b1000;
        send_job(7'h33, 4'b1000, 1'b1, a);
        i_unit_done = 4'b0010;
        tick();
        i_unit_done = '0;
        check("t30_busy",  64'(o_busy), 64'b1001);
        check("t30_urst",  64'(o_unit_rstn), 64'b1101);
        check("t30_valid", 64'(o_unit_valid), 64'b1000);
        tick();
        check("t30_urst_back", 64'(o_unit_rstn), 64'hf);
        i_unit_ready = '1;
        drain(5);

        // No unit ready for 20 cycles, then only unit 2.
        do_reset();
        i_unit_ready = '0;
        send_job(7'h40, 4'b0100, 1'b1, a);
        repeat (20) tick();
        check("t31_state", 64'(o_state), 64'(ST_FULL));
        check("t31_ready", 64'(o_ready), 64'd0);
        check("t31_valid", 64'(o_unit_valid), 64'd0);
        check("t31_busy",  64'(o_busy), 64'd0);
        i_unit_ready = 4'b0100;
        drain(5);
        check("t31_busy_after", 64'(o_busy), 64'b0100);
        i_unit_ready = '1;

        // Reset while a job is held: dropped, and the next job goes to unit 0.
        do_reset();
        send_job(7'h50, 4'b0000, 1'b0, a);
        rstn = 1'b0;
        tick();
        check("t32_rst_busy",  64'(o_busy), 64'd0);
        check("t32_rst_state", 64'(o_state), 64'(ST_EMPTY));
        check("t32_rst_ready", 64'(o_ready), 64'd0);
        check("t32_rst_urst",  64'(o_unit_rstn), 64'd0);
        rstn = 1'b1;
        repeat (8) tick();
        check("t32_busy",     64'(o_busy), 64'd0);
        check("t32_inflight", 64'(o_inflight), 64'd0);
        check("t32_state",    64'(o_state), 64'(ST_EMPTY));
        check("t32_nonce",    64'(o_v_nonce), 64'd0);
        send_job(7'h51, 4'b0001, 1'b1, a);
        drain(5);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        check("t32_inflight_drop", 64'(o_busy), 64'd0);
        check("t32_urst_rel",      64'(o_unit_rstn), 64'hf);

`ifdef EXPLODE_SCHED_WATCHDOG_EN
        // Unit 0 never reports done; the watchdog must reclaim it after WD busy cycles.
        do_reset();
        send_job(7'h60, 4'b0001, 1'b1, a);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_busy[0]) n++;
            else if (n > 0) break;
        end
        check("t33_busy_cycles", 64'(n), 64'(WD));
        check("t33_busy",        64'(o_busy), 64'd0);
        check("t33_timeout",     64'(o_timeout), 64'b0001);
        check("t33_urst",        64'(o_unit_rstn), 64'b1110);
        tick();
        check("t33_urst_back",   64'(o_unit_rstn), 64'hf);
        check("t33_sticky",      64'(o_timeout), 64'b0001);
`else
        check("no_wdog_timeout", 64'(o_timeout), 64'd0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/explode_scheduler.md
EXPLODE_SCHEDULER -- requirements
Module: explode_scheduler

Interface
REQ-001 SHALL have parameter state_width, default 1600: width of the Keccak state passed through to the units.
REQ-002 SHALL have parameter nonce_width, default 7: width of the job nonce/slot tag.
REQ-003 SHALL have parameter N_UNITS, default 4: number of explode units scheduled, range 2..16.
REQ-004 SHALL have parameter WDOG_CYCLES, default 65535: busy-cycle limit per unit (used only with the macro in REQ-024).
REQ-005 SHALL have ports: clk  in  1  clock; rstn  in  1  reset, synchronous, active-low (one clock).
REQ-006 SHALL have ports: i_valid  in  1  job offered; i_v_state  in  state_width  job state; i_v_nonce  in  nonce_width  job nonce; o_ready  out  1  job accepted when high with i_valid.
REQ-007 SHALL have ports: o_v_state  out  state_width  held job state (shared bus); o_v_nonce  out  nonce_width  held nonce; o_unit_valid  out  N_UNITS  one-hot issue strobe.
REQ-008 SHALL have ports: i_unit_ready  in  N_UNITS  unit can take a job; i_unit_done  in  N_UNITS  unit finished (1-cycle pulse); o_busy  out  N_UNITS  unit owns a job; o_inflight  out  clog2(N_UNITS+1)  popcount of o_busy; o_unit_rstn  out  N_UNITS  per-unit reset; o_timeout  out  N_UNITS  sticky watchdog flag.

Function
REQ-009 SHALL implement FSM EMPTY -> FULL -> ISSUE -> EMPTY; o_ready = (state==EMPTY) && rstn.
REQ-010 SHALL capture i_v_state/i_v_nonce into the holding register on the edge where i_valid && o_ready, entering FULL.
REQ-011 SHALL treat unit k as eligible when !o_busy[k] && i_unit_ready[k].
REQ-012 SHALL, in FULL with >=1 eligible unit, grant round-robin starting at (last_grant+1) mod N_UNITS, set o_busy[grant], update last_grant, and enter ISSUE on the next edge; with none eligible, remain FULL.
REQ-013 SHALL, in ISSUE, drive o_unit_valid one-hot on the granted unit for exactly one cycle with o_v_state/o_v_nonce stable, then return to EMPTY.
REQ-014 SHALL give minimum latency of two cycles from acceptance edge to o_unit_valid high; maximum throughput one job per three cycles.
REQ-015 SHALL clear o_busy[k] on the edge after i_unit_done[k]; done on a non-busy unit is ignored.
REQ-016 SHALL apply simultaneous done on unit j and grant to unit k (j!=k) both in the same edge; a unit freed by done is eligible from the following cycle only.
REQ-017 SHALL drive o_unit_rstn[k] low for exactly one cycle, registered, on the edge after i_unit_done[k] for a busy unit, and low while rstn is low.
REQ-018 SHALL keep o_v_state/o_v_nonce holding the last captured job while EMPTY.
REQ-019 SHALL compute o_inflight combinationally from o_busy.

Reset
REQ-020 SHALL, while rstn low at a clock edge, set state EMPTY, holding registers 0, o_busy 0, last_grant N_UNITS-1 (unit 0 granted first), o_unit_valid 0, o_unit_rstn 0, o_timeout 0, watchdog counters 0.
REQ-021 SHALL hold o_ready 0 while rstn is low.
REQ-022 SHALL drop any held or in-flight job on reset mid-operation with no o_unit_valid issued afterwards.
REQ-023 SHALL release o_unit_rstn to all-ones on the first edge with rstn high.

Configuration
REQ-024 SHALL, with EXPLODE_SCHED_WATCHDOG_EN defined, keep a per-unit counter incrementing while o_busy[k], cleared on grant/done; on reaching WDOG_CYCLES, clear o_busy[k], pulse o_unit_rstn[k] low one cycle, set o_timeout[k] until reset.
REQ-025 SHALL, without EXPLODE_SCHED_WATCHDOG_EN, instantiate no counters, tie o_timeout to 0, and keep all ports present.

Structure
REQ-026 SHALL place default state_width, nonce_width, N_UNITS and FSM state encodings in shared package cn_explode_pkg.
REQ-027 SHALL implement the round-robin pick in sub-module rr_arbiter (request vector, last pointer in; one-hot grant, index, any-grant out).

Verification
REQ-028 SHALL cover: reset, all units ready, one job nonce 0x05 -> o_unit_valid=4'b0001 two cycles after acceptance, o_v_nonce=0x05, o_busy=4'b0001, o_inflight=1.
REQ-029 SHALL cover: four back-to-back jobs, all ready -> grants 0001,0010,0100,1000 each 3 cycles apart; fifth job stays FULL, o_ready=0, until done[2] -> next grant 0100.
REQ-030 SHALL cover: done[1] same cycle as grant to unit 3 -> o_busy gains bit3, loses bit1 same edge; o_unit_rstn[1] low one cycle.
REQ-031 SHALL cover: i_unit_ready=4'b0000 with job held 20 cycles -> no o_unit_valid, o_ready=0; ready[2]=1 -> grant 0100.
REQ-032 SHALL cover: rstn low during FULL -> job dropped, o_busy=0, no issue after release; next job goes to unit 0.
REQ-033 SHALL cover (macro on, WDOG_CYCLES=16): unit 0 never done -> o_busy[0] clears after 16 busy cycles, o_timeout=4'b0001, o_unit_rstn[0] low one cycle.
